// File: rtl/ltch_sched_pkg.sv
// Shared types and helpers for the latch write scheduler and its round-robin arbiter.
// Holds the FSM state encoding and the rotating-priority scan function.
package ltch_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    HOLD  = 2'd3
  } sched_state_t;

  localparam int RR_MAX = 32;
  localparam int RR_IW  = 5;

  // Returns the first set request index found scanning ptr, ptr+1, ... mod n, or -1 if none.
  // The loop is bounded by RR_MAX so it unrolls to a fixed structure for any n <= RR_MAX.
  function automatic int rr_first(input logic [RR_MAX-1:0] req, input int ptr, input int n);
    int pos;
    int idx;
    pos = -1;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && (pos < 0) && req[idx[RR_IW-1:0]]) pos = idx;
    end
    return pos;
  endfunction

endpackage

// File: rtl/gnrl_rr_arb.sv
// Generic rotating-priority arbiter: one-hot grant plus encoded index, starting the scan at i_ptr.
// Purely combinational; the owner keeps and advances the pointer.
module gnrl_rr_arb
  import ltch_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
)(
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_gnt_idx
);

  int w_pos;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_pos     = rr_first(RR_MAX'(i_req), int'(i_ptr), NREQ);
    if (i_en && (w_pos >= 0)) begin
      o_gnt_idx        = w_pos[PW-1:0];
      o_gnt[o_gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ltch_wr_sched.sv
// Round-robin write scheduler for a latch array: stage data, pulse one latch enable, hold data a cycle.
// Sequence per write is IDLE -> SETUP -> WRITE -> HOLD -> IDLE, so the enable never overlaps a data change.
module ltch_wr_sched
  import ltch_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = $clog2(NREQ)
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdat,
  output logic [DEPTH-1:0]     ltch_en,
  output logic [DW-1:0]        ltch_wdat,
  output logic                 busy,
  output logic                 wr_done,
  output logic                 wr_err
);

  sched_state_t     r_state;
  sched_state_t     w_nxt_state;
  logic [PW-1:0]    r_rr_ptr;
  logic [PW-1:0]    w_nxt_ptr;
  logic [PW-1:0]    w_gnt_idx;
  logic [NREQ-1:0]  w_gnt;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    w_sel_addr;
  logic [DW-1:0]    r_wdat;
  logic [DW-1:0]    w_sel_wdat;
  logic [DEPTH-1:0] r_ltch_en;
  logic [DEPTH-1:0] w_ltch_en_nxt;
  logic             r_wr_done;
  logic             r_wr_err;
  logic             w_arb_en;
  logic             w_accept;
  logic             w_addr_oob;

  // Gating with rst_n keeps req_ready low for the whole time reset is asserted.
  assign w_arb_en = rst_n && (r_state == IDLE);

  gnrl_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_rr_ptr),
    .i_en      (w_arb_en),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign req_ready = w_gnt;
  assign w_accept  = |(w_gnt & req_valid);
  assign w_nxt_ptr = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : (w_gnt_idx + PW'(1));

  always_comb begin
    w_sel_addr = '0;
    w_sel_wdat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = req_addr[i*AW +: AW];
        w_sel_wdat = req_wdat[i*DW +: DW];
      end
    end
  end

  // Out-of-range addresses only exist when DEPTH leaves unused codes in AW bits.
  generate
    if ((2 ** AW) == DEPTH) begin : g_oob_none
      assign w_addr_oob = 1'b0;
    end else begin : g_oob_chk
      assign w_addr_oob = (r_addr >= AW'(DEPTH));
    end
  endgenerate

  always_comb begin
    w_nxt_state   = r_state;
    w_ltch_en_nxt = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_nxt_state = SETUP;
      end
      SETUP: begin
        if (w_addr_oob) begin
          w_nxt_state = IDLE;
        end else begin
          w_nxt_state = WRITE;
          for (int i = 0; i < DEPTH; i++) w_ltch_en_nxt[i] = (r_addr == AW'(i));
        end
      end
      WRITE:   w_nxt_state = HOLD;
      HOLD:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_nxt_state;
      if (w_accept) r_rr_ptr <= w_nxt_ptr;
    end
  end

  // Staged data and address move only on an accept edge, which can only happen in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_wdat <= '0;
    end else if (w_accept) begin
      r_addr <= w_sel_addr;
      r_wdat <= w_sel_wdat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ltch_en <= '0;
      r_wr_done <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_ltch_en <= w_ltch_en_nxt;
      r_wr_done <= (r_state == HOLD);
      r_wr_err  <= (r_state == SETUP) && w_addr_oob;
    end
  end

  assign ltch_en   = r_ltch_en;
  assign ltch_wdat = r_wdat;
  assign busy      = (r_state != IDLE);
  assign wr_done   = r_wr_done;
  assign wr_err    = r_wr_err;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      a_ltch_en_onehot: assert ($onehot0(ltch_en))
        else $error("ltch_en not one-hot-or-zero: %b", ltch_en);
      a_ready_onehot: assert ($onehot0(req_ready))
        else $error("req_ready not one-hot-or-zero: %b", req_ready);
      a_valid_known: assert (!$isunknown(req_valid))
        else $fatal(1, "req_valid is unknown while out of reset: %b", req_valid);
    end
  end
`endif

endmodule

// File: tb/tb_ltch_wr_sched.sv
// Directed bench for ltch_wr_sched with a write scoreboard and a behavioural latch array.
// A second instance with DEPTH=6 exercises the out-of-range address path.
module tb_ltch_wr_sched;

  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int N2    = 2;
  localparam int D2    = 6;
  localparam int A2    = 3;

  logic                clk       = 1'b0;
  logic                rst_n     = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*AW-1:0]  req_addr  = '0;
  logic [NREQ*DW-1:0]  req_wdat  = '0;
  logic [NREQ-1:0]     req_ready;
  logic [DEPTH-1:0]    ltch_en;
  logic [DW-1:0]       ltch_wdat;
  logic                busy;
  logic                wr_done;
  logic                wr_err;

  logic [N2-1:0]       req_valid2 = '0;
  logic [N2*A2-1:0]    req_addr2  = '0;
  logic [N2*DW-1:0]    req_wdat2  = '0;
  logic [N2-1:0]       req_ready2;
  logic [D2-1:0]       ltch_en2;
  logic [DW-1:0]       ltch_wdat2;
  logic                busy2;
  logic                wr_done2;
  logic                wr_err2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
  } wr_t;

  wr_t           sbq[$];
  wr_t           monExp;
  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] expMem [DEPTH];
  int            checks   = 0;
  int            failures = 0;
  int            order [5] = '{0, 1, 2, 3, 0};
  logic [3:0]    expGnt;

  ltch_wr_sched #(.NREQ(NREQ), .DEPTH(DEPTH), .DW(DW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdat  (req_wdat),
    .ltch_en   (ltch_en),
    .ltch_wdat (ltch_wdat),
    .busy      (busy),
    .wr_done   (wr_done),
    .wr_err    (wr_err)
  );

  ltch_wr_sched #(.NREQ(N2), .DEPTH(D2), .DW(DW)) u_dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid2),
    .req_ready (req_ready2),
    .req_addr  (req_addr2),
    .req_wdat  (req_wdat2),
    .ltch_en   (ltch_en2),
    .ltch_wdat (ltch_wdat2),
    .busy      (busy2),
    .wr_done   (wr_done2),
    .wr_err    (wr_err2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_wdat[i*DW +: DW] = d;
  endtask

  task automatic expectWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sbq.push_back('{addr: a, wdat: d});
    expMem[a] = d;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n      = 1'b0;
    req_valid  = '1;
    req_valid2 = '1;
    #1;
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_ltch_en", ltch_en, 0);
    checkOutput("rst_ltch_wdat", ltch_wdat, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done_err", {wr_done, wr_err}, 0);
    @(negedge clk);
    req_valid  = '0;
    req_valid2 = '0;
    rst_n      = 1'b1;
  endtask

  // Behavioural transparent latches, one per entry, preset to a known pattern.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A5_0000 + DW'(i);
    forever begin
      @(ltch_en or ltch_wdat);
      for (int i = 0; i < DEPTH; i++) if (ltch_en[i]) mem[i] = ltch_wdat;
    end
  end

  // Every enable pulse must match the oldest write still expected.
  always @(negedge clk) begin
    if (rst_n && (ltch_en != '0)) begin
      if (sbq.size() == 0) begin
        checkOutput("sb_unexpected_write", ltch_en, 0);
      end else begin
        monExp = sbq.pop_front();
        checkOutput("sb_ltch_en", ltch_en, 64'd1 << monExp.addr);
        checkOutput("sb_ltch_wdat", ltch_wdat, monExp.wdat);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) expMem[i] = 32'hA5A5_0000 + DW'(i);
    doReset();

    // Single write: accept, SETUP, WRITE, HOLD, done.
    applyStimulus(0, 3'd3, 32'hDEAD_BEEF);
    #1 checkOutput("t1_ready", req_ready, 4'b0001);
    expectWrite(3'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    req_valid = '0;
    checkOutput("t1_c1_busy", busy, 1);
    checkOutput("t1_c1_en", ltch_en, 0);
    checkOutput("t1_c1_wdat", ltch_wdat, 32'hDEAD_BEEF);
    checkOutput("t1_c1_ready", req_ready, 0);
    @(negedge clk);
    checkOutput("t1_c2_en", ltch_en, 8'b0000_1000);
    checkOutput("t1_c2_busy", busy, 1);
    @(negedge clk);
    checkOutput("t1_c3_en", ltch_en, 0);
    checkOutput("t1_c3_wdat", ltch_wdat, 32'hDEAD_BEEF);
    checkOutput("t1_c3_busy_done", {busy, wr_done}, 2'b10);
    @(negedge clk);
    checkOutput("t1_c4_busy_done", {busy, wr_done}, 2'b01);
    @(negedge clk);
    checkOutput("t1_c5_done", wr_done, 0);

    // Out-of-range address on the DEPTH=6 instance, then a pointer-advance check.
    req_valid2[0]     = 1'b1;
    req_addr2[2:0]    = 3'd7;
    req_wdat2[31:0]   = 32'hBAD0_0007;
    #1 checkOutput("t4_ready", req_ready2, 2'b01);
    @(negedge clk);
    req_valid2 = '0;
    checkOutput("t4_c1_busy", busy2, 1);
    checkOutput("t4_c1_en", ltch_en2, 0);
    checkOutput("t4_c1_err", wr_err2, 0);
    checkOutput("t4_c1_wdat", ltch_wdat2, 32'hBAD0_0007);
    @(negedge clk);
    checkOutput("t4_c2_busy", busy2, 0);
    checkOutput("t4_c2_err", wr_err2, 1);
    checkOutput("t4_c2_done", wr_done2, 0);
    checkOutput("t4_c2_en", ltch_en2, 0);
    req_addr2  = {3'd5, 3'd5};
    req_wdat2  = {32'h1111_5000, 32'h0000_5000};
    req_valid2 = 2'b11;
    #1 checkOutput("t4_ptr_advanced", req_ready2, 2'b10);
    @(negedge clk);
    req_valid2 = '0;
    checkOutput("t4_c3_err_done", {wr_err2, wr_done2}, 0);
    @(negedge clk);
    checkOutput("t4_c4_en", ltch_en2, 6'b10_0000);
    checkOutput("t4_c4_wdat", ltch_wdat2, 32'h1111_5000);
    repeat (2) @(negedge clk);
    checkOutput("t4_c6_done_busy", {wr_done2, busy2}, 2'b10);

    // All requesters valid continuously: grants rotate 0,1,2,3,0.
    doReset();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, AW'(i), 32'hC0DE_0000 + DW'(i));
    for (int k = 0; k < 5; k++) begin
      expGnt = 4'(1 << order[k]);
      #1 checkOutput($sformatf("t2_grant%0d", k), req_ready, expGnt);
      expectWrite(AW'(order[k]), 32'hC0DE_0000 + DW'(order[k]));
      @(negedge clk);
      if (k == 4) req_valid = '0;
      repeat (3) @(negedge clk);
    end
    checkOutput("t2_end_done_busy", {wr_done, busy}, 2'b10);

    // Request arriving during WRITE waits for IDLE and never leaks onto ltch_wdat early.
    applyStimulus(0, 3'd4, 32'h4040_4040);
    #1 checkOutput("t3_ready0", req_ready, 4'b0001);
    expectWrite(3'd4, 32'h4040_4040);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    applyStimulus(2, 3'd5, 32'h2222_2222);
    #1 checkOutput("t3_write_ready", req_ready, 0);
    checkOutput("t3_write_wdat", ltch_wdat, 32'h4040_4040);
    @(negedge clk);
    checkOutput("t3_hold_ready", req_ready, 0);
    checkOutput("t3_hold_wdat", ltch_wdat, 32'h4040_4040);
    @(negedge clk);
    #1 checkOutput("t3_idle_ready2", req_ready, 4'b0100);
    expectWrite(3'd5, 32'h2222_2222);
    @(negedge clk);
    req_valid = '0;
    checkOutput("t3_wdat2", ltch_wdat, 32'h2222_2222);
    repeat (3) @(negedge clk);
    checkOutput("t3_done", wr_done, 1);

    // Asynchronous reset in the middle of a WRITE.
    doReset();
    applyStimulus(1, 3'd6, 32'h6666_0001);
    #1 checkOutput("t5_ready", req_ready, 4'b0010);
    expectWrite(3'd6, 32'h6666_0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checkOutput("t5_write_en", ltch_en, 8'b0100_0000);
    #2 rst_n = 1'b0;
    #1 checkOutput("t5_async_en", ltch_en, 0);
    checkOutput("t5_async_busy", busy, 0);
    applyStimulus(1, 3'd4, 32'h4444_0004);
    applyStimulus(3, 3'd7, 32'h3333_3333);
    #1 checkOutput("t5_rst_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("t5_post_ready", req_ready, 4'b0010);
    checkOutput("t5_post_busy", busy, 0);
    expectWrite(3'd4, 32'h4444_0004);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    checkOutput("t5_done", wr_done, 1);
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) checkOutput($sformatf("hold_entry%0d", i), mem[i], expMem[i]);
    checkOutput("sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
